// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decoder-side
// instruction handshake and redirect.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order memory requests,
// buffers responses with their PC and squashes stale traffic on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned USED_W = CNT_W + 1;

  logic             run_q, run_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      pc_mem_q   [BUF_DEPTH];
  logic [31:0]      pc_mem_d   [BUF_DEPTH];
  logic [31:0]      data_mem_q [BUF_DEPTH];
  logic [31:0]      data_mem_d [BUF_DEPTH];

  logic [USED_W-1:0] used;
  logic              inst_valid_c;
  logic              pop;
  logic              push;
  logic              req_valid_c;
  logic              accept;
  logic              rsp;
  logic [31:0]       tgt;

  always_comb begin
    used         = USED_W'(outstanding_q) + USED_W'(count_q);
    inst_valid_c = (count_q != '0);
    pop          = inst_valid_c & bus.inst_ready;
    // A slot freed by this cycle's pop may be re-credited at once for full throughput.
    req_valid_c  = run_q & ~bus.redirect &
                   ((used - USED_W'(pop)) < USED_W'(BUF_DEPTH));
    accept       = req_valid_c & bus.imem_req_ready;
    rsp          = bus.imem_rsp_valid;
    push         = rsp & (drop_cnt_q == '0);
    tgt          = bus.redirect_target & ~32'h3;

    run_d         = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp);
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      pc_mem_d[i]   = pc_mem_q[i];
      data_mem_d[i] = data_mem_q[i];
    end

    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);

    if (bus.redirect) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc_d = tgt;
      rsp_pc_d   = tgt;
      drop_cnt_d = outstanding_q - CNT_W'(rsp);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = rsp_pc_q;
        data_mem_d[wr_ptr_q] = bus.imem_rsp_data;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        rsp_pc_d             = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_mem_q[i]   <= pc_mem_d[i];
        data_mem_q[i] <= data_mem_d[i];
      end
    end
  end

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = inst_valid_c;
  assign bus.inst           = data_mem_q[rd_ptr_q];
  assign bus.inst_pc        = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against an in-order PC-stream model
// and a variable-latency instruction memory model.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] tgt; int lat; logic [31:0] exp_pc; } vec_t;

  mreq_t       mq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_acc = 0;
  int          n_del = 0;
  logic [31:0] exp_pc = 32'h0;
  bit          acc, del;
  logic [31:0] acc_addr, del_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, sample, return at the next falling edge.
  task automatic step(input logic rdy, input logic irdy, input logic redir, input logic [31:0] tgt);
    mreq_t m;
    int    d;
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memword(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    bus.imem_req_ready  = rdy;
    bus.inst_ready      = irdy;
    bus.redirect        = redir;
    bus.redirect_target = tgt;
    #1;
    acc = bus.imem_req_valid & rdy;
    acc_addr = bus.imem_req_addr;
    if (acc) begin
      n_acc++;
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      m.addr = acc_addr;
      m.due  = d;
      mq.push_back(m);
    end
    del = bus.inst_valid & irdy & ~redir;
    del_pc = bus.inst_pc;
    if (del) begin
      n_del++;
      chk("stream_pc", bus.inst_pc, exp_pc);
      chk("stream_inst", bus.inst, memword(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = tgt & ~32'h3;
    @(negedge clk);
  endtask

  task automatic first_del(input string name, input logic [31:0] expv, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      seen = del;
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: no delivery within %0d cycles, expected pc %h", name, budget, expv);
    end else begin
      chk(name, del_pc, expv);
    end
  endtask

  // Asynchronous reset asserted between clock edges; memory model shares the reset.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    mq.delete();
    last_due = 0;
    exp_pc = 32'h0;
    cyc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("run_gate", 32'(bus.imem_req_valid), 32'h0);
  endtask

  vec_t vt[4];
  int   k;

  initial begin
    rst_n = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = 32'h0;
    bus.inst_ready      = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    vt[0] = '{32'h0000_0203, 1, 32'h0000_0200};
    vt[1] = '{32'h0000_0100, 3, 32'h0000_0100};
    vt[2] = '{32'hABCD_EF07, 2, 32'hABCD_EF04};
    vt[3] = '{32'h0000_0FFD, 1, 32'h0000_0FFC};
    @(negedge clk);

    // Streaming after reset with a 1-cycle memory: one request and one instruction per cycle.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("no_req_release_cycle", 32'(acc), 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("s1_acc", 32'(acc), 32'h1);
      chk("s1_addr", acc_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("s1_del", 32'(del), 32'h1);
        chk("s1_del_pc", del_pc, 32'(4 * (i - 2)));
      end
    end

    // Decoder stalled: credit limit caps requests at two; head stays stable.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    k = n_acc;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (bus.inst_valid) begin
        chk("s2_hold_pc", bus.inst_pc, 32'h0);
        chk("s2_hold_inst", bus.inst, memword(32'h0));
      end
    end
    chk("s2_req_count", 32'(n_acc - k), 32'd2);
    chk("s2_valid", 32'(bus.inst_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("s2_resume_del", 32'(del), 32'h1);
      chk("s2_resume_pc", del_pc, 32'(4 * i));
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("s3_inflight", 32'(mq.size()), 32'd2);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    first_del("s3_first_pc", 32'h0000_0100, 20);

    // Redirect table: misaligned targets are word-aligned; next inst follows at +4.
    for (int v = 0; v < 4; v++) begin
      lat_min = vt[v].lat;
      lat_max = vt[v].lat;
      repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, vt[v].tgt);
      first_del("tbl_first_pc", vt[v].exp_pc, 30);
      first_del("tbl_next_pc", vt[v].exp_pc + 32'd4, 30);
    end

    // Back-to-back redirects: the later target wins.
    lat_min = 2;
    lat_max = 2;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    first_del("b2b_first_pc", 32'h0000_0080, 30);

    // PC wrap at the top of the address space.
    lat_min = 1;
    lat_max = 1;
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_acc0", 32'(acc), 32'h1);
    chk("wrap_addr0", acc_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_acc1", 32'(acc), 32'h1);
    chk("wrap_addr1", acc_addr, 32'h0000_0000);
    first_del("wrap_del0", 32'hFFFF_FFFC, 10);
    first_del("wrap_del1", 32'h0000_0000, 10);

    // Mid-stream reset, then restart from the reset PC.
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    do_reset();
    first_del("restart_pc", 32'h0000_0000, 10);

    // Random ready/latency/redirect traffic checked against the stream model.
    lat_min = 1;
    lat_max = 3;
    k = n_del;
    for (int i = 0; i < 1000; i++) begin
      logic rd, ir, rr;
      rd = ($urandom_range(3, 0) != 0);
      ir = 1'($urandom_range(1, 0));
      rr = ($urandom_range(31, 0) == 0);
      step(rd, ir, rr, $urandom);
    end
    chk("rand_progress", 32'(n_del - k > 100), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
